// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern mode controller: a debounced button or frame timer
// requests an advance, which is committed only on frame_start.
module pattern_sequencer #(
  parameter int NUM_MODES       = 4,
  parameter int MODE_W          = 2,
  parameter int AUTO_FRAMES     = 120,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              auto_en,
  input  logic              frame_start,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              req_pending
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FC_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(AUTO_FRAMES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} db_state_t;

  db_state_t       db_state;
  logic [DB_W-1:0] db_cnt;
  logic [FC_W-1:0] fcnt;
  logic            sync1;
  logic            sync2;
  logic            btn_rise;
  logic            auto_tick;
  logic            advance;
  logic            req_pending_next;

  // A rise is recognised in the cycle that completes the stable-high window,
  // so the request latch sees it on the same edge the FSM reaches HIGH.
  assign btn_rise         = (db_state == WAIT_HIGH) && sync2 && (db_cnt == DB_LAST);
  assign auto_tick        = auto_en && frame_start && (fcnt == FC_LAST);
  assign advance          = frame_start && (req_pending || auto_tick);
  assign req_pending_next = (req_pending && !frame_start) || btn_rise;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      db_state     <= LOW;
      db_cnt       <= '0;
      fcnt         <= '0;
      mode         <= '0;
      mode_changed <= 1'b0;
      req_pending  <= 1'b0;
    end else begin
      sync1 <= btn_next;
      sync2 <= sync1;

      case (db_state)
        LOW: begin
          if (sync2) begin
            db_state <= WAIT_HIGH;
            db_cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            db_state <= LOW;
          end else if (db_cnt == DB_LAST) begin
            db_state <= HIGH;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HIGH: begin
          if (!sync2) begin
            db_state <= WAIT_LOW;
            db_cnt   <= '0;
          end
        end
        default: begin
          if (sync2) begin
            db_state <= HIGH;
          end else if (db_cnt == DB_LAST) begin
            db_state <= LOW;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
      endcase

      req_pending  <= req_pending_next;
      mode_changed <= advance;

      if (advance) begin
        mode <= (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
      end

      // Any advance restarts the auto timer so the new mode gets a full period.
      if (advance || !auto_en) begin
        fcnt <= '0;
      end else if (frame_start) begin
        fcnt <= fcnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: a behavioural model predicts every
// cycle's outputs and queues each expected new mode for the monitor.
module tb_pattern_sequencer;

  localparam int D  = 4;
  localparam int AF = 3;
  localparam int NM = 3;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn;
  logic          auto_en;
  logic          fs;
  logic [MW-1:0] mode;
  logic          mode_changed;
  logic          req_pending;

  int errors = 0;
  int checks = 0;
  int mc_count = 0;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .NUM_MODES(NM), .MODE_W(MW), .AUTO_FRAMES(AF), .DEBOUNCE_CYCLES(D)
  ) dut (
    .pixel_clk(clk), .reset(reset), .btn_next(btn), .auto_en(auto_en),
    .frame_start(fs), .mode(mode), .mode_changed(mode_changed),
    .req_pending(req_pending)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: debounced level flips after D+1 consecutive
  // synchronized samples disagreeing with it; frames counted since last advance.
  int  m_mode, m_fcnt, m_s1, m_s2, m_level, m_run;
  bit  m_req, m_mc, m_valid;
  int  exp_q[$];

  always @(posedge clk) begin
    bit rise, tick, adv;
    if (reset) begin
      m_mode = 0; m_fcnt = 0; m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
      m_req = 0; m_mc = 0; m_valid = 1;
    end else begin
      rise = 0;
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = m_s2;
          m_run = 0;
          rise = (m_level == 1);
        end
      end else begin
        m_run = 0;
      end
      tick  = auto_en && fs && (m_fcnt == AF - 1);
      adv   = fs && (m_req || tick);
      m_req = (m_req && !fs) || rise;
      m_mc  = adv;
      if (adv) begin
        m_mode = (m_mode + 1) % NM;
        exp_q.push_back(m_mode);
      end
      if (adv || !auto_en) m_fcnt = 0;
      else if (fs) m_fcnt++;
      m_s2 = m_s1;
      m_s1 = int'(btn);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("mode", int'(mode), m_mode);
      check("req_pending", int'(req_pending), int'(m_req));
      check("mode_changed", int'(mode_changed), int'(m_mc));
      if (mode_changed) begin
        mc_count++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_change", 1, 0);
        end else begin
          check("sb_new_mode", int'(mode), exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    @(posedge clk); #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic press();
    btn = 1'b1; idle(D + 4);
    btn = 1'b0; idle(D + 6);
  endtask

  initial begin
    int c0, hold;
    reset = 1'b1; btn = 1'b1; auto_en = 1'b0; fs = 1'b0;

    // Reset held two cycles with button high and frame_start pulsing.
    repeat (2) begin @(posedge clk); #1 fs = ~fs; end
    fs = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (D + 1) begin
      @(negedge clk);
      check("rst_req", int'(req_pending), 0);
      check("rst_mode", int'(mode), 0);
    end
    btn = 1'b0;
    do_reset();
    idle(10);

    // Debounced press and first advance.
    @(posedge clk); #1 btn = 1'b1;
    repeat (D + 2) @(posedge clk);
    #1 check("press_early", int'(req_pending), 0);
    @(posedge clk); #1 check("press_latency", int'(req_pending), 1);
    idle(3);
    frame();
    check("press_mode", int'(mode), 1);
    check("press_mc", int'(mode_changed), 1);
    check("press_req_clr", int'(req_pending), 0);
    @(posedge clk); #1 check("press_mc_end", int'(mode_changed), 0);
    btn = 1'b0; idle(15);

    // Glitch of three cycles is rejected.
    btn = 1'b1; idle(3); btn = 1'b0; idle(15);
    check("glitch_req", int'(req_pending), 0);
    check("glitch_mode", int'(mode), 1);

    // Auto cycling with wrap.
    do_reset();
    auto_en = 1'b1;
    c0 = mc_count;
    for (int k = 1; k <= 9; k++) begin
      frame();
      check("auto_mode", int'(mode), (k / 3) % NM);
      idle(8);
    end
    check("auto_pulses", mc_count - c0, 3);

    // Button request coinciding with the auto tick.
    frame(); idle(8);
    frame(); idle(2);
    press();
    check("simul_req", int'(req_pending), 1);
    frame();
    check("simul_mode", int'(mode), 1);
    check("simul_req_clr", int'(req_pending), 0);
    idle(8);
    for (int k = 1; k <= 3; k++) begin
      frame();
      check("simul_next_auto", int'(mode), (k == 3) ? 2 : 1);
      idle(8);
    end

    // Rise in the same cycle as frame_start survives to the next frame.
    auto_en = 1'b0;
    do_reset();
    idle(5);
    @(posedge clk); #1 btn = 1'b1;
    repeat (D + 2) @(posedge clk);
    #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
    check("coinc_mode", int'(mode), 0);
    check("coinc_req", int'(req_pending), 1);
    btn = 1'b0; idle(10);
    frame();
    check("coinc_next_mode", int'(mode), 1);

    // Two presses in one frame collapse to one advance.
    idle(5);
    press();
    press();
    frame();
    check("double_mode", int'(mode), 2);
    idle(5);
    frame();
    check("double_single", int'(mode), 2);
    idle(5);

    // Randomized traffic including wide frame pulses and stray resets.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (hold == 0) begin
        btn  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      fs = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0; fs = 1'b0; btn = 1'b0;
    idle(5);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Frame-synchronous mode controller for the VGA test-pattern path. Selects which pattern the pixel pipeline renders. It advances on a debounced push-button request or on an automatic frame-count timer. It commits a new mode only at the start of a frame, so the display never shows a torn frame with mixed patterns.

## Interface
- `NUM_MODES`, default 4: number of pattern modes; legal 2..2^MODE_W.
- `MODE_W`, default 2: width of `mode`.
- `AUTO_FRAMES`, default 120: frames per mode in auto-cycle; legal ≥1.
- `DEBOUNCE_CYCLES`, default 250000: stable `pixel_clk` cycles required to accept a button level change; legal ≥1.

Ports:
- `pixel_clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `btn_next`, in, 1: raw asynchronous push-button, active-high.
- `auto_en`, in, 1: level; enables automatic cycling.
- `frame_start`, in, 1: one-cycle pulse from the timing generator at pixel (0,0).
- `mode`, out, MODE_W: current pattern mode, registered.
- `mode_changed`, out, 1: one-cycle pulse, high in the first cycle the new `mode` is visible.
- `req_pending`, out, 1: button request accepted and waiting for the next frame start.

## Operation
- **Input sync.** `btn_next` passes through a 2-flop synchronizer (`sync1`, `sync2`). Only `sync2` is used downstream.
- **Debounce FSM.** States are `LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`, with counter `db_cnt` (width fits `DEBOUNCE_CYCLES`).
  - `LOW`: on `sync2`=1, go to `WAIT_HIGH` with `db_cnt`=0.
  - `WAIT_HIGH`: if `sync2`=0, return to `LOW`. Else, if `db_cnt`=`DEBOUNCE_CYCLES`-1, go to `HIGH` and generate `btn_rise`. Else increment `db_cnt`.
  - `HIGH`: on `sync2`=0, go to `WAIT_LOW` with `db_cnt`=0.
  - `WAIT_LOW`: the mirror of `WAIT_HIGH`. If `sync2`=1, return to `HIGH`. On `db_cnt`=`DEBOUNCE_CYCLES`-1 with `sync2`=0, go to `LOW`. No event is generated.
- **Request latch.** `req_pending_next` = (`req_pending` & ~`frame_start`) | `btn_rise`.
  - Any number of accepted presses within one frame collapse to a single advance.
  - A `btn_rise` in the same cycle as `frame_start` is not consumed by that frame. It stays pending for the next one.
- **Frame counter** `fcnt` (width fits `AUTO_FRAMES`):
  - `auto_en`=0: `fcnt` is held at 0.
  - `auto_en`=1: on each `frame_start`, `fcnt` increments.
  - `auto_tick` = `auto_en` & `frame_start` & (`fcnt`=`AUTO_FRAMES`-1).
- **Advance.** On a `frame_start` cycle where `req_pending` or `auto_tick` is true:
  - `mode` becomes `mode`+1, wrapping from `NUM_MODES`-1 to 0.
  - `fcnt` is cleared, whether the advance came from the button or the timer.
  - `req_pending` is cleared (subject to the latch rule above).
  - `mode_changed` is 1 in the following cycle.
- **Simultaneous request and timer.** If `req_pending` and `auto_tick` are both true at the same frame start, `mode` advances by exactly one.
- **Arithmetic.** All arithmetic is unsigned. `mode` never leaves the range 0..`NUM_MODES`-1.

## Timing
- **Reset values** (synchronous `reset`=1 at a clock edge):
  - `mode`=0, `mode_changed`=0, `req_pending`=0.
  - FSM in `LOW`, `db_cnt`=0, `fcnt`=0, synchronizer flops 0.
- **Reset mid-operation:** a pending request and any debounce in progress are discarded.
- **`frame_start` asserted together with `reset`:** ignored.
- **Button latency:** `btn_next` is first sampled high at edge E. With the input held steady, `req_pending` is 1 after edge E+2+`DEBOUNCE_CYCLES`.
- **Advance latency:** with `frame_start`=1 at edge F, `mode` shows the new value and `mode_changed`=1 after edge F. `mode_changed` returns to 0 after edge F+1.
- **Pulse shape:** `mode_changed` is exactly one cycle per advance and never fires on two consecutive cycles unless `frame_start` does.
- **Glitch rejection:** any `sync2` pulse shorter than `DEBOUNCE_CYCLES` cycles produces no request.
- **Wrong `frame_start` width:** wider pulses are the caller's error. Each high cycle is treated as a separate frame start.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `AUTO_FRAMES`=3, `NUM_MODES`=3 (`MODE_W`=2).
- **Reset:** hold `reset` 2 cycles with `btn_next`=1 and `frame_start` pulsing → `mode`=0, `req_pending`=0, `mode_changed`=0 throughout, and after release until debounce completes.
- **Debounced press:**
  - Raise `btn_next` at edge 10 and hold → `req_pending`=1 after edge 16.
  - Then `frame_start` at edge 20 → `mode`=1 and `mode_changed`=1 after edge 20, `req_pending`=0.
- **Glitch rejection:** `btn_next` high for 3 cycles, then low → `req_pending` stays 0, `mode` unchanged.
- **Auto cycling and wrap:**
  - `auto_en`=1 with `frame_start` every 10 cycles → `mode` goes 0→1 on the 3rd frame start, 1→2 on the 6th, and 2→0 on the 9th.
  - `mode_changed` pulses exactly 3 times.
- **Simultaneous events:** `req_pending`=1 at the same `frame_start` as `auto_tick` (`fcnt`=2) → `mode` advances by exactly 1 and `fcnt`=0. The next auto advance comes 3 frame starts later.
- **Coincident rise:**
  - `btn_rise` lands in the same cycle as `frame_start` with `req_pending`=0 → no advance at that frame, `req_pending`=1 afterwards.
  - The next `frame_start` advances `mode` by 1.
  - Two separate accepted presses within one frame → a single advance.
